// File: rtl/cic_comp_decimator.sv
// Decimate-by-2 compensation FIR placed behind a CIC down-sampler.
// A single shared multiplier walks the TAPS coefficients serially.
// One output is produced for every second input strobe.
// Handshake: eni is a one-cycle qualifier; `in` is sampled on every clock edge where eni=1.
// out_valid is a one-cycle pulse on the cycle `out` takes a new value.
// There is no back-pressure.
module cic_comp_decimator #(
    parameter int W    = 10,
    parameter int CW   = 12,
    parameter int TAPS = 16,
    // h[k] occupies bits [k*CW +: CW]; h[0] weights the newest sample
    parameter logic [TAPS*CW-1:0] COEF = {{((TAPS-2)*CW){1'b0}}, CW'(1024), CW'(1024)}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         eni,
    input  logic [W-1:0] in,
    input  logic         ovf_clr,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         busy,
    output logic         ovf
);

    localparam int PW    = W + CW;
    localparam int AW    = W + CW + $clog2(TAPS);
    localparam int IW    = $clog2(TAPS);
    localparam int CNTW  = $clog2(TAPS + 1);
    // The sample store is at least twice TAPS deep.
    // Writes that land during a MAC sequence advance away from the window being read.
    // They cannot wrap around onto it.
    localparam int DW    = IW + 1;
    localparam int DEPTH = 2 ** DW;

    localparam logic signed [AW-1:0] RND_HALF = AW'(1) << (CW - 2);
    localparam logic signed [AW-1:0] SAT_MAX  = AW'((2 ** (W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN  = -SAT_MAX - AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [DW-1:0]          wp_q, wp_d;
    logic [DW-1:0]          trig_ptr_q, trig_ptr_d;
    logic                   start_q, start_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic                   pvalid_q, pvalid_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [W-1:0]           out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic signed [W-1:0]    mem_q [DEPTH];

    logic                   trigger, accept, overrun;
    logic [IW-1:0]          idx;
    logic [DW-1:0]          rd_addr;
    logic signed [W-1:0]    rd_data;
    logic signed [CW-1:0]   coef_k;
    logic signed [AW-1:0]   rnd, shifted;

    // Next-state logic for the FSM, datapath, flags and output register
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        wp_d        = wp_q;
        trig_ptr_d  = trig_ptr_q;
        start_d     = 1'b0;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        pvalid_d    = 1'b0;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;

        idx     = cnt_q[IW-1:0];
        rd_addr = trig_ptr_q - DW'(idx);
        rd_data = mem_q[rd_addr];
        coef_k  = COEF[idx*CW +: CW];
        rnd     = acc_q + RND_HALF;
        shifted = rnd >>> (CW - 1);

        // A trigger is accepted when idle with nothing pending.
        // It is also accepted in the final ROUND cycle, so back-to-back sequences abut.
        trigger = eni && phase_q;
        accept  = trigger && (((state_q == S_IDLE) && !start_q) || (state_q == S_ROUND));
        overrun = trigger && !accept;

        if (eni) begin
            phase_d = ~phase_q;
            wp_d    = wp_q + DW'(1);
        end
        if (accept) begin
            start_d    = 1'b1;
            trig_ptr_d = wp_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_MAC;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                if (cnt_q != CNTW'(TAPS)) begin
                    prod_d   = rd_data * coef_k;
                    pvalid_d = 1'b1;
                    cnt_d    = cnt_q + CNTW'(1);
                end else begin
                    state_d = S_ROUND;
                end
                if (pvalid_q) begin
                    acc_d = acc_q + {{(AW-PW){prod_q[PW-1]}}, prod_q};
                end
            end
            S_ROUND: begin
                if (shifted > SAT_MAX) begin
                    out_d = SAT_MAX[W-1:0];
                end else if (shifted < SAT_MIN) begin
                    out_d = SAT_MIN[W-1:0];
                end else begin
                    out_d = shifted[W-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || (accept && (state_q == S_ROUND));

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (overrun) begin
            ovf_d = 1'b1;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            wp_q        <= '0;
            trig_ptr_q  <= '0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
            pvalid_q    <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wp_q        <= wp_d;
            trig_ptr_q  <= trig_ptr_d;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            pvalid_q    <= pvalid_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    // Sample store: every strobe writes, even mid-sequence; reset clears all entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (eni) begin
            mem_q[wp_q] <= in;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cic_comp_decimator.sv
// Bench for cic_comp_decimator using coefficients h[k] = 64*(k+1).
// Expected outputs come from a direct convolution over the recent input history.
module tb_cic_comp_decimator;

    localparam int W    = 10;
    localparam int CW   = 12;
    localparam int TAPS = 16;

    function automatic logic [TAPS*CW-1:0] mk_coef();
        logic [TAPS*CW-1:0] r;
        r = '0;
        for (int k = 0; k < TAPS; k++) begin
            r[k*CW +: CW] = CW'(64 * (k + 1));
        end
        return r;
    endfunction

    localparam logic [TAPS*CW-1:0] TB_COEF = mk_coef();

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         eni = 1'b0;
    logic [W-1:0] din = '0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] out;
    logic         out_valid;
    logic         busy;
    logic         ovf;

    cic_comp_decimator #(.W(W), .CW(CW), .TAPS(TAPS), .COEF(TB_COEF)) dut (
        .clk(clk), .rst_n(rst_n), .eni(eni), .in(din), .ovf_clr(ovf_clr),
        .out(out), .out_valid(out_valid), .busy(busy), .ovf(ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           cur_edge = 0;
    int           hist[$];
    bit           m_phase = 1'b0;
    bit           m_ovf = 1'b0;
    int           m_last = -1000;
    int           m_prev = -1000;
    bit           m_chain = 1'b0;
    logic [W-1:0] exp_q[$];
    int           exp_edge_q[$];
    bit           rand_clr = 1'b0;
    bit           hold_clr = 1'b0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cur_edge, act, exp);
        end
    endtask

    function automatic longint model_out();
        longint acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            int i = hist.size() - 1 - k;
            longint x = (i >= 0) ? longint'(hist[i]) : 0;
            acc += longint'(64 * (k + 1)) * x;
        end
        acc = (acc + 1024) >>> 11;
        if (acc > 511) acc = 511;
        if (acc < -512) acc = -512;
        return acc;
    endfunction

    function automatic bit exp_busy(int c);
        return (c >= m_last + 1 && c <= m_last + TAPS + 2) ||
               (c >= m_prev + 1 && c <= m_prev + TAPS + 2) ||
               (m_chain && c == m_last);
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        exp_edge_q.delete();
        m_phase = 1'b0;
        m_ovf   = 1'b0;
        m_last  = -1000;
        m_prev  = -1000;
        m_chain = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        bit over = 1'b0;
        if (eni) begin
            hist.push_back(int'($signed(din)));
            if (hist.size() > TAPS) void'(hist.pop_front());
            if (m_phase) begin
                if (cur_edge >= m_last + TAPS + 3) begin
                    m_chain = (cur_edge == m_last + TAPS + 3);
                    m_prev  = m_last;
                    m_last  = cur_edge;
                    exp_q.push_back(W'(model_out()));
                    exp_edge_q.push_back(cur_edge + TAPS + 3);
                end else begin
                    over = 1'b1;
                end
            end
            m_phase = ~m_phase;
        end
        m_ovf = over ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        cur_edge++;
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic set_clr();
        ovf_clr = hold_clr || (rand_clr && ($urandom_range(0, 5) == 0));
    endtask

    task automatic send(logic [W-1:0] v, int gap);
        eni = 1'b1;
        din = v;
        set_clr();
        tick();
        eni = 1'b0;
        for (int i = 1; i < gap; i++) begin
            set_clr();
            tick();
        end
    endtask

    task automatic idle(int n);
        eni = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_clr();
            tick();
        end
    endtask

    task automatic impulse_run();
        send(W'(256), 20);
        for (int i = 0; i < 19; i++) send('0, 20);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out", out, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            chk("busy", busy, exp_busy(cur_edge));
            chk("ovf", ovf, m_ovf);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    logic [W-1:0] e;
                    int           ee;
                    e  = exp_q.pop_front();
                    ee = exp_edge_q.pop_front();
                    chk("out", longint'($signed(out)), longint'($signed(e)));
                    chk("out_edge", cur_edge, ee);
                end
            end
        end
    end

    initial begin
        int guard;
        // reset held with eni toggling
        din = W'(300);
        for (int i = 0; i < 10; i++) begin
            eni = (i % 2 == 0);
            tick();
        end
        eni   = 1'b0;
        rst_n = 1'b1;
        idle(5);

        // impulse response: 16, 32, ..., 128 then 0
        impulse_run();
        idle(10);

        // saturation and gain
        for (int i = 0; i < 20; i++) send(W'(511), 10);
        for (int i = 0; i < 20; i++) send(W'(-512), 10);
        for (int i = 0; i < 20; i++) send(W'(100), 10);
        idle(30);

        // overrun: strobes every 4 cycles, then a clear pulse
        for (int i = 0; i < 12; i++) send(W'($urandom_range(0, 1023)), 4);
        idle(25);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        idle(3);
        // overrun while clear is held: set wins on those edges
        for (int i = 0; i < 12; i++) send(W'($urandom_range(0, 1023)), 4);
        hold_clr = 1'b1;
        for (int i = 0; i < 12; i++) send(W'($urandom_range(0, 1023)), 4);
        hold_clr = 1'b0;
        idle(30);

        // random spacing, data and clears
        rand_clr = 1'b1;
        for (int i = 0; i < 300; i++) send(W'($urandom_range(0, 1023)), $urandom_range(2, 12));
        rand_clr = 1'b0;
        idle(30);

        // asynchronous reset in the middle of a sequence
        guard = 0;
        while (guard < 4) begin
            eni = 1'b1;
            din = W'(200);
            tick();
            eni = 1'b0;
            if (m_last == cur_edge) break;
            idle(9);
            guard++;
        end
        chk("mid_trigger_seen", m_last, cur_edge);
        idle(7);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_out", out, 0);
        chk("async_busy", busy, 0);
        chk("async_out_valid", out_valid, 0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // impulse again: must match a fresh run
        impulse_run();
        idle(40);

        chk("pending_outputs", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
